rf_scan_controller: RTL and testbench
=====================================

// Module: rf_scan_controller
// PURPOSE
//  Sequences the receptive-field selector over one image for one conv layer.
//  Steps rowNumber over 0..H-F (stride 1) and column over half 0 / half 1,
//  giving (H-F+1)*2 windows per image. Each window is offered to the
//  downstream conv/MAC array through a valid/ready handshake.
//  Sits between the layer top-level FSM (start/done) and the selector/conv datapath.
// PARAMETERS
//  H          32  image height in pixels; H-F must be <= 63 (6-bit row index)
//  W          32  image width in pixels; used only for the column-half count
//  F           5  kernel size
//  SETTLE_CYC  1  cycles the selector output must settle after row/column change; 0..7
// PORTS
//  clk          in   1  clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  start        in   1  pulse; begin a scan, sampled only in IDLE
//  abort        in   1  level; abandon the scan, return to IDLE next cycle
//  rowNumber    out  6  row index driven to the selector
//  column       out  6  half select to the selector: 0 = first half, 1 = second half
//  rf_valid     out  1  selector output is stable and offered downstream
//  rf_ready     in   1  downstream accepts the window
//  win_idx      out  7  sequence number of the current window: row*2+column
//  busy         out  1  high in every state except IDLE
//  done         out  1  one-cycle pulse after the last window is accepted
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE; rowNumber=0, column=0, win_idx=0,
//    rf_valid=0, busy=0, done=0. All outputs are registered.
//  States:
//    IDLE: start=1 -> row=0, col=0, win_idx=0, settle counter=SETTLE_CYC,
//      go to SETTLE (or directly to OFFER if SETTLE_CYC=0).
//    SETTLE: count down; when the count reaches 0 -> OFFER; rf_valid=0.
//    OFFER: rf_valid=1; hold row/col/win_idx stable while rf_ready=0.
//      rf_valid&rf_ready with column=0 -> column=1.
//      rf_valid&rf_ready with column=1 and row<H-F -> row+1, column=0.
//      Either advance: win_idx+1, reload counter, go to SETTLE (or stay in
//      OFFER with a fresh window if SETTLE_CYC=0).
//      rf_valid&rf_ready with column=1 and row==H-F -> DONE.
//    DONE: done=1 for exactly one cycle, rf_valid=0 -> IDLE; indices hold last values.
//  Latency: start -> first rf_valid after SETTLE_CYC+1 cycles. Each window costs
//    SETTLE_CYC+1 cycles minimum when rf_ready is held high.
//  Once rf_valid is raised it never drops without a handshake, except on abort
//    or reset.
//  abort has priority over a handshake in the same cycle: next state IDLE,
//    rf_valid=0, done is NOT pulsed, indices reset to 0.
//  start while busy is ignored. start and abort together in IDLE: abort wins,
//    and the block stays in IDLE.
//  rf_ready while rf_valid=0 is ignored.
//  Reset mid-scan: immediate return to reset values; there is no resume.
//  Row and column never wrap; win_idx max = 2*(H-F)+1.
// STRUCTURE
//  Shared package: state enum (IDLE, SETTLE, OFFER, DONE), index widths
//    ROW_W=6 and WIN_W=7, and the function n_windows(H,F)=2*(H-F+1).
//  Optional sub-module rf_settle_timer: a loadable down-counter with a zero flag.
//  Everything else stays flat in one always_ff block plus the next-state logic.
// TESTING
//  1 Default params, rf_ready tied high, start pulse -> 56 handshakes in (row,col)
//    order (0,0),(0,1)..(27,1); win_idx 0..55; done pulses once, 112 cycles after
//    the first rf_valid.
//  2 rf_ready random 30% duty -> rowNumber, column and win_idx stable across every
//    stalled cycle; the same 56-window order; there are no dropped or duplicated
//    windows.
//  3 abort at win_idx=10 in the same cycle as a handshake -> IDLE next cycle,
//    rf_valid=0, no done pulse, indices=0; a new start gives a full 56-window scan.
//  4 rst_n low during SETTLE at row 5 -> all outputs at reset values immediately,
//    without waiting for a clock edge; start after release -> scan starts at (0,0).
//  5 SETTLE_CYC=0, H=8, F=5 -> 8 windows, with rf_valid held continuously while
//    rf_ready=1; done on the cycle after (3,1) is accepted.
//  6 start pulsed again mid-scan and rf_ready pulsed in IDLE -> both ignored;
//    scan order and the done timing are unchanged.

Source files
------------

// File: rtl/rf_scan_controller_pkg.sv
// Shared types and sizing for the receptive-field scan controller.
// Holds the state encoding, index widths and the window-count helper.
package rf_scan_controller_pkg;

  localparam int unsigned ROW_W = 6;
  localparam int unsigned WIN_W = 7;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StOffer,
    StDone
  } state_e;

  function automatic int unsigned n_windows(input int unsigned h, input int unsigned f);
    return 2 * (h - f + 1);
  endfunction

endpackage

// File: rtl/rf_scan_controller_settle_timer.sv
// Loadable down-counter with a zero flag, used to let the selector output settle.
module rf_settle_timer
  import rf_scan_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rf_scan_controller.sv
// Steps (row, column-half) windows over one image and offers each one downstream
// through a valid/ready handshake, with a settle delay after every index change.
module rf_scan_controller
  import rf_scan_controller_pkg::*;
#(
  parameter int unsigned H          = 32,
  parameter int unsigned W          = 32,
  parameter int unsigned F          = 5,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  output logic [ROW_W-1:0] o_row_number,
  output logic [ROW_W-1:0] o_column,
  output logic             o_rf_valid,
  input  logic             i_rf_ready,
  output logic [WIN_W-1:0] o_win_idx,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned      NCols      = (W >= 2) ? 2 : 1;
  localparam logic [ROW_W-1:0] LastCol    = ROW_W'(NCols - 1);
  localparam logic [WIN_W-1:0] LastWin    = WIN_W'(n_windows(H, F) - 1);
  localparam logic             NoSettle   = (SETTLE_CYC == 0);
  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

  state_e           r_state;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] r_col;
  logic [WIN_W-1:0] r_win;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic w_hs;
  logic w_last;
  logic w_begin;
  logic w_load;
  logic w_zero;

  assign w_hs    = (r_state == StOffer) && r_valid && i_rf_ready;
  assign w_last  = (r_win == LastWin);
  assign w_begin = (r_state == StIdle) && i_start && !i_abort;
  assign w_load  = w_begin || (w_hs && !w_last && !i_abort);

  rf_settle_timer u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (SettleLoad),
    .i_dec      (r_state == StSettle),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_row   <= '0;
      r_col   <= '0;
      r_win   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_abort) begin
      // Abort beats any handshake or start in the same cycle.
      r_state <= StIdle;
      r_row   <= '0;
      r_col   <= '0;
      r_win   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_win   <= '0;
            r_busy  <= 1'b1;
            r_valid <= NoSettle;
            r_state <= NoSettle ? StOffer : StSettle;
          end
        end
        StSettle: begin
          if (w_zero) begin
            r_valid <= 1'b1;
            r_state <= StOffer;
          end
        end
        StOffer: begin
          if (w_hs) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              if (r_col != LastCol) begin
                r_col <= r_col + 1'b1;
              end else begin
                r_row <= r_row + 1'b1;
                r_col <= '0;
              end
              r_win   <= r_win + 1'b1;
              r_valid <= NoSettle;
              r_state <= NoSettle ? StOffer : StSettle;
            end
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_row_number = r_row;
  assign o_column     = r_col;
  assign o_rf_valid   = r_valid;
  assign o_win_idx    = r_win;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_rf_scan_controller.sv
// Scoreboard bench for rf_scan_controller: default instance plus a short
// H=8/F=5/SETTLE_CYC=0 instance for the back-to-back case.
module tb_rf_scan_controller;

  typedef struct packed {
    logic [5:0] row;
    logic [5:0] col;
    logic [6:0] win;
  } win_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, ready;
  logic [5:0] row, col;
  logic [6:0] win;
  logic       rfv, busy, done;
  logic       start8, abort8, ready8;
  logic [5:0] row8, col8;
  logic [6:0] win8;
  logic       rfv8, busy8, done8;

  int   n_vec = 0;
  int   n_err = 0;
  win_t sb[$];

  always #5 clk = ~clk;

  rf_scan_controller u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .o_row_number(row), .o_column(col), .o_rf_valid(rfv), .i_rf_ready(ready),
    .o_win_idx(win), .o_busy(busy), .o_done(done)
  );

  rf_scan_controller #(.H(8), .W(32), .F(5), .SETTLE_CYC(0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(start8), .i_abort(abort8),
    .o_row_number(row8), .o_column(col8), .o_rf_valid(rfv8), .i_rf_ready(ready8),
    .o_win_idx(win8), .o_busy(busy8), .o_done(done8)
  );

  task automatic push_scan(input int last_row);
    for (int r = 0; r <= last_row; r++)
      for (int c = 0; c < 2; c++)
        sb.push_back('{row: 6'(r), col: 6'(c), win: 7'(r * 2 + c)});
  endtask

  // Full 56-window scan on u_dut; exp_done > 0 checks done's cycle index,
  // counting the first rf_valid cycle as cycle 1.
  task automatic run_scan(input string name, input int duty, input bit poke,
                          input int exp_done);
    int   cyc = 0;
    bit   seen = 0, dseen = 0, pv = 0, phs = 0, hs;
    win_t pw = '0, got, exp;
    sb.delete();
    push_scan(27);
    @(negedge clk);
    start = 1'b1;
    for (int t = 0; t < 4000 && !dseen; t++) begin
      @(negedge clk);
      start = poke && busy && (t == 10 || t == 60);
      got = '{row: row, col: col, win: win};
      if (seen) cyc++;
      else if (rfv) begin seen = 1; cyc = 1; end
      if (pv && !phs) begin
        n_vec++;
        if (!rfv || got !== pw) begin
          n_err++;
          $display("FAIL %s stall_hold: valid=%b idx=%h required valid=1 idx=%h",
                   name, rfv, got, pw);
        end
      end
      if (done) begin
        dseen = 1;
        n_vec++;
        if (sb.size() != 0) begin
          n_err++;
          $display("FAIL %s window_count: %0d left required 0", name, sb.size());
        end
        if (exp_done > 0) begin
          n_vec++;
          if (cyc != exp_done) begin
            n_err++;
            $display("FAIL %s done_time: cycle %0d required %0d", name, cyc, exp_done);
          end
        end
      end
      ready = ($urandom_range(99) < duty);
      hs = rfv && ready;
      if (hs) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL %s extra_window: got %h required none", name, got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL %s window: got %h required %h", name, got, exp);
          end
        end
      end
      pv = rfv; phs = hs; pw = got;
    end
    start = 1'b0;
    if (!dseen) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout: done=0 required 1", name);
    end
    @(negedge clk);
    ready = 1'b0;
    n_vec++;
    if ({rfv, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL %s after_done: vbd=%b required 000", name, {rfv, busy, done});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; ready = 0; start8 = 0; abort8 = 0; ready8 = 0;
    #12;
    n_vec++;
    if ({row, col, win, rfv, busy, done} !== '0 ||
        {row8, col8, win8, rfv8, busy8, done8} !== '0) begin
      n_err++;
      $display("FAIL reset_values: dut=%h dut8=%h required 0",
               {row, col, win, rfv, busy, done}, {row8, col8, win8, rfv8, busy8, done8});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_abort();
    bit hit = 0;
    @(negedge clk);
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      if (rfv && win == 7'd10) begin hit = 1; abort = 1'b1; end
    end
    @(negedge clk);
    abort = 1'b0; ready = 1'b0;
    n_vec++;
    if (!hit || {rfv, busy, done, row, col, win} !== '0) begin
      n_err++;
      $display("FAIL abort_state: hit=%b out=%h required hit=1 out=0",
               hit, {rfv, busy, done, row, col, win});
    end
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      n_vec++;
      if (done || busy) begin
        n_err++;
        $display("FAIL abort_no_done: done=%b busy=%b required 0 0", done, busy);
      end
    end
    // start and abort together in IDLE: stays idle
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy || rfv) begin
      n_err++;
      $display("FAIL start_abort_idle: busy=%b valid=%b required 0 0", busy, rfv);
    end
    run_scan("abort_rescan", 100, 0, 112);
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    @(negedge clk);
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      if (row == 6'd5 && busy && !rfv) hit = 1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (!hit || {row, col, win, rfv, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: hit=%b out=%h required hit=1 out=0",
               hit, {row, col, win, rfv, busy, done});
    end
    ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_scan("reset_rescan", 100, 0, 112);
  endtask

  task automatic test_back_to_back();
    bit   seen = 0, dseen = 0;
    int   last_hs = -10;
    win_t got, exp;
    sb.delete();
    push_scan(3);
    @(negedge clk);
    start8 = 1'b1; ready8 = 1'b1;
    for (int t = 0; t < 100 && !dseen; t++) begin
      @(negedge clk);
      start8 = 1'b0;
      got = '{row: row8, col: col8, win: win8};
      if (done8) begin
        dseen = 1;
        n_vec++;
        if (sb.size() != 0 || t != last_hs + 1) begin
          n_err++;
          $display("FAIL b2b_done: left=%0d t=%0d required left=0 t=%0d",
                   sb.size(), t, last_hs + 1);
        end
      end else if (seen) begin
        n_vec++;
        if (!rfv8) begin
          n_err++;
          $display("FAIL b2b_valid_gap: valid=0 required 1 at t=%0d", t);
        end
      end
      if (rfv8) begin
        seen = 1;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL b2b_extra: got %h required none", got);
        end else begin
          exp = sb.pop_front();
          last_hs = t;
          if (got !== exp) begin
            n_err++;
            $display("FAIL b2b_window: got %h required %h", got, exp);
          end
        end
      end
    end
    ready8 = 1'b0;
    if (!dseen) begin
      n_vec++; n_err++;
      $display("FAIL b2b_timeout: done=0 required 1");
    end
  endtask

  task automatic test_ignored_inputs();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      ready = t[0];
      n_vec++;
      if (rfv || busy || done) begin
        n_err++;
        $display("FAIL idle_ready: vbd=%b required 000", {rfv, busy, done});
      end
    end
    ready = 1'b0;
    run_scan("poke_start", 100, 1, 112);
  endtask

  initial begin
    test_reset();
    run_scan("ready_high", 100, 0, 112);
    run_scan("ready_random", 30, 0, 0);
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_ignored_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
